led_frame_loader: RTL and testbench
===================================

Name: led_frame_loader

Overview:
- Upstream sequencer for the LED serializer (P2S).
- Holds a multi-byte LED frame and feeds it to the serializer one BIT_WIDTH-bit word at a time. For each word it presents par_in, pulses start, and waits for the serializer's idle flag (P2S EN).
- Accepts new frames through a valid/ready handshake.
- Periodically re-sends the last frame so the external shift-register chain stays refreshed.

Parameters:
- BIT_WIDTH, 8, word width; must equal the serializer's BIT_WIDTH.
- NUM_BYTES, 2, words per frame.
- REFRESH_CYCLES, 50000, idle cycles between automatic re-sends.
- TIMEOUT_CYCLES, 64, maximum cycles spent in PREP+WAIT for one word before abort.

Ports:
- clk  in  1  system clock, all flops on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- frame_data  in  NUM_BYTES*BIT_WIDTH  frame; word k = frame_data[k*BIT_WIDTH +: BIT_WIDTH].
- frame_valid  in  1  frame_data valid.
- frame_ready  out  1  high when a frame can be accepted.
- refresh_en  in  1  enables periodic re-send.
- p2s_idle  in  1  serializer EN (high = idle, ready for start).
- par_in  out  BIT_WIDTH  word to serializer.
- start  out  1  one-cycle load pulse to serializer.
- busy  out  1  high while a frame is being sent.
- frame_done  out  1  one-cycle pulse after the last word completes.
- timeout_err  out  1  sticky abort flag.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; shadow frame, par_in, word index, timeout counter and refresh counter all 0.
  - have_frame=0; start=0, busy=0, frame_done=0, timeout_err=0, frame_ready=1.
- FSM states: IDLE, PREP, LOAD, ARM, WAIT, DONE.
- Combinational outputs: frame_ready = (state==IDLE); busy = (state!=IDLE).
- start = (state==LOAD), decoded from the state register only. It never depends on p2s_idle combinationally, because the serializer's EN depends on start and a dependency here would form a loop.
- IDLE:
  - frame_valid=1 → capture frame_data into shadow, set have_frame=1, clear timeout_err, set idx=NUM_BYTES-1, go to PREP.
  - Otherwise, if refresh_en && have_frame, the refresh counter increments. At REFRESH_CYCLES-1 → idx=NUM_BYTES-1, go to PREP.
  - frame_valid and refresh expiry in the same cycle → the new frame wins.
  - refresh_en=0 holds the refresh counter at 0.
- PREP:
  - par_in <= shadow word[idx].
  - p2s_idle=1 → LOAD; otherwise stay. The timeout counter runs.
- LOAD: start=1 for exactly one cycle → ARM. par_in is stable.
- ARM: one cycle, start=0; timeout counter cleared → WAIT. This lets the serializer drop idle.
- WAIT:
  - p2s_idle=1: if idx==0 → DONE; else idx-1 → PREP.
  - The timeout counter runs.
- Timeout: in PREP or WAIT, when the counter reaches TIMEOUT_CYCLES-1 → timeout_err=1, go to IDLE, no frame_done. have_frame is kept, so refresh retries later.
- DONE: frame_done=1 for one cycle, refresh counter cleared → IDLE.
- Counters:
  - The timeout counter clears on entry to PREP and in ARM.
  - Counter widths are clog2 of their limits; no wrap, they saturate at the limit.
- par_in changes only in PREP and is held through LOAD, ARM and WAIT.
- Word order: highest index first; word 0 is sent last.
- frame_valid while busy is ignored (frame_ready=0); the shadow is unchanged.
- Reset mid-frame returns everything to reset values immediately. The partial frame is abandoned and no refresh occurs until a new frame is accepted.
- Latency:
  - Accept at edge N, p2s_idle=1 → start high during cycle N+2 (PREP at N+1, LOAD at N+2).
  - Per word: 3 cycles + serializer busy time.

Test Plan:
- Basic frame: BIT_WIDTH=8, NUM_BYTES=2, frame_data=16'hA55A, serializer model idle-low for 9 cycles after start → par_in=8'hA5 then 8'h5A, exactly two single-cycle start pulses each with the matching par_in, frame_done one pulse, busy low after it, frame_ready back to 1.
- Backpressure: p2s_idle=0 at accept for 10 cycles → FSM in PREP, start never high; p2s_idle=1 → start pulses on the second following cycle, transfer completes normally.
- Timeout: TIMEOUT_CYCLES=16, p2s_idle stuck 0 after the first start → timeout_err=1 after 16 WAIT cycles, busy=0, frame_ready=1, no frame_done; a new frame clears timeout_err.
- Refresh: REFRESH_CYCLES=100, refresh_en=1 after one frame → a re-send starts every 100 idle cycles with identical par_in sequence; refresh_en=0 → no re-send; with no frame ever accepted → no start.
- Collision/ignore:
  - frame_valid with 16'h1234 while busy → ignored, the original frame is still sent.
  - frame_valid coincident with refresh expiry → the new frame's words are sent.
- Async reset: assert rst_n=0 mid-WAIT without a clock edge → start=0, busy=0, par_in=0, frame_ready=1 immediately; after release no refresh occurs.

Source files
------------

// File: rtl/led_frame_loader.sv
// LED frame loader: holds a multi-word frame and feeds it word by word
// to the P2S serializer, with periodic refresh and a per-word timeout.
module led_frame_loader #(
  parameter int BIT_WIDTH      = 8,
  parameter int NUM_BYTES      = 2,
  parameter int REFRESH_CYCLES = 50000,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_BYTES*BIT_WIDTH-1:0] frame_data,
  input  logic                           frame_valid,
  output logic                           frame_ready,
  input  logic                           refresh_en,
  input  logic                           p2s_idle,
  output logic [BIT_WIDTH-1:0]           par_in,
  output logic                           start,
  output logic                           busy,
  output logic                           frame_done,
  output logic                           timeout_err
);

  localparam int FW = NUM_BYTES * BIT_WIDTH;
  localparam int IW =
    (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int RW =
    (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  localparam logic [IW-1:0] IDX_TOP = IW'(NUM_BYTES - 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] REF_MAX = RW'(REFRESH_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, PREP, LOAD, ARM, WAIT, DONE
  } state_e;

  state_e         state_q, state_d;
  logic [FW-1:0]  shadow_q, shadow_d;
  logic [BIT_WIDTH-1:0] par_in_q, par_in_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [RW-1:0]  ref_q, ref_d;
  logic           have_q, have_d;
  logic           err_q, err_d;

  // start is a pure state decode so the serializer's EN cannot loop back
  assign start       = (state_q == LOAD);
  assign frame_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign frame_done  = (state_q == DONE);
  assign par_in      = par_in_q;
  assign timeout_err = err_q;

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    par_in_d = par_in_q;
    idx_d    = idx_q;
    tmo_d    = tmo_q;
    ref_d    = ref_q;
    have_d   = have_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (frame_valid) begin
          shadow_d = frame_data;
          have_d   = 1'b1;
          err_d    = 1'b0;
          idx_d    = IDX_TOP;
          tmo_d    = '0;
          ref_d    = '0;
          state_d  = PREP;
        end else if (refresh_en && have_q) begin
          if (ref_q == REF_MAX) begin
            ref_d   = '0;
            idx_d   = IDX_TOP;
            tmo_d   = '0;
            state_d = PREP;
          end else begin
            ref_d = ref_q + 1'b1;
          end
        end else if (!refresh_en) begin
          ref_d = '0;
        end
      end
      PREP: begin
        par_in_d = shadow_q[idx_q*BIT_WIDTH +: BIT_WIDTH];
        if (p2s_idle) begin
          state_d = LOAD;
        end else if (tmo_q == TMO_MAX) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      LOAD: state_d = ARM;
      ARM: begin
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (p2s_idle) begin
          if (idx_q == '0) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q - 1'b1;
            tmo_d   = '0;
            state_d = PREP;
          end
        end else if (tmo_q == TMO_MAX) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      DONE: begin
        ref_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      par_in_q <= '0;
      idx_q    <= '0;
      tmo_q    <= '0;
      ref_q    <= '0;
      have_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      par_in_q <= par_in_d;
      idx_q    <= idx_d;
      tmo_q    <= tmo_d;
      ref_q    <= ref_d;
      have_q   <= have_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_led_frame_loader.sv
// Directed bench for led_frame_loader with a simple
// serializer model that stays busy 9 cycles per start.
module tb_led_frame_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] frame_data = '0;
  logic        frame_valid = 1'b0;
  logic        frame_ready;
  logic        refresh_en = 1'b0;
  logic        p2s_idle;
  logic [7:0]  par_in;
  logic        start;
  logic        busy;
  logic        frame_done;
  logic        timeout_err;

  logic        hold_lo = 1'b0;
  logic [3:0]  scnt = '0;
  logic        start_prev = 1'b0;
  int          dbl = 0;
  int          done_cnt = 0;
  logic [7:0]  words[$];

  int total = 0;
  int bad   = 0;
  int n;
  int d0;

  led_frame_loader #(
    .BIT_WIDTH(8), .NUM_BYTES(2),
    .REFRESH_CYCLES(100), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .frame_data(frame_data), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .refresh_en(refresh_en),
    .p2s_idle(p2s_idle), .par_in(par_in), .start(start),
    .busy(busy), .frame_done(frame_done),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  assign p2s_idle = (scnt == 4'd0) && !hold_lo;

  always @(posedge clk) begin
    if (start) scnt <= 4'd9;
    else if (scnt != 4'd0) scnt <= scnt - 4'd1;
  end

  always @(negedge clk) begin
    if (start) begin
      words.push_back(par_in);
      if (start_prev) dbl <= dbl + 1;
    end
    start_prev <= start;
    if (frame_done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d);
    frame_data  = d;
    frame_valid = 1'b1;
    tick(1);
    frame_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!frame_done && k < 200) begin
      tick(1);
      k++;
    end
    chk(tag, {31'd0, frame_done}, 32'd1);
    tick(1);
  endtask

  task automatic wait_start(input string tag, input int lim,
                            output int cnt);
    cnt = 0;
    while (!start && cnt < lim) begin
      tick(1);
      cnt++;
    end
    chk(tag, {31'd0, start}, 32'd1);
  endtask

  task automatic chk_seq(input string tag,
                         input logic [15:0] d,
                         input int reps);
    logic [7:0] g;
    chk({tag, "_n"}, words.size(), 2 * reps);
    for (int i = 0; i < 2 * reps; i++) begin
      g = (i < words.size()) ? words[i] : 8'hxx;
      chk({tag, "_w"}, {24'd0, g},
          {24'd0, (i % 2 == 0) ? d[15:8] : d[7:0]});
    end
    words.delete();
  endtask

  initial begin
    #12;
    chk("rst_ready", {31'd0, frame_ready}, 32'd1);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_start", {31'd0, start}, 32'd0);
    chk("rst_par",   {24'd0, par_in}, 32'd0);
    chk("rst_done",  {31'd0, frame_done}, 32'd0);
    chk("rst_err",   {31'd0, timeout_err}, 32'd0);
    rst_n = 1'b1;
    tick(2);

    // basic frame and accept-to-start latency
    d0 = done_cnt;
    send(16'hA55A);
    chk("lat_prep", {31'd0, start}, 32'd0);
    tick(1);
    chk("lat_start", {31'd0, start}, 32'd1);
    wait_done("basic_done");
    chk("basic_busy", {31'd0, busy}, 32'd0);
    chk("basic_ready", {31'd0, frame_ready}, 32'd1);
    chk("basic_dcnt", done_cnt - d0, 32'd1);
    chk("basic_dbl", dbl, 32'd0);
    chk_seq("basic", 16'hA55A, 1);

    // backpressure held in PREP
    hold_lo = 1'b1;
    send(16'hC33C);
    tick(10);
    chk("bp_nostart", words.size(), 32'd0);
    chk("bp_busy", {31'd0, busy}, 32'd1);
    hold_lo = 1'b0;
    chk("bp_s0", {31'd0, start}, 32'd0);
    tick(1);
    chk("bp_s1", {31'd0, start}, 32'd1);
    wait_done("bp_done");
    chk("bp_err", {31'd0, timeout_err}, 32'd0);
    chk_seq("bp", 16'hC33C, 1);

    // serializer stuck busy after the first start
    d0 = done_cnt;
    send(16'h0F0F);
    wait_start("to_start", 20, n);
    hold_lo = 1'b1;
    n = 0;
    while (!timeout_err && n < 40) begin
      tick(1);
      n++;
    end
    chk("to_cycles", n, 32'd18);
    chk("to_err", {31'd0, timeout_err}, 32'd1);
    chk("to_busy", {31'd0, busy}, 32'd0);
    chk("to_ready", {31'd0, frame_ready}, 32'd1);
    chk("to_nodone", done_cnt - d0, 32'd0);
    hold_lo = 1'b0;
    words.delete();
    tick(12);
    send(16'h1122);
    chk("to_clear", {31'd0, timeout_err}, 32'd0);
    wait_done("to_done2");
    chk_seq("to_new", 16'h1122, 1);

    // frame_valid while busy is ignored
    send(16'hBEEF);
    tick(1);
    frame_data  = 16'h1234;
    frame_valid = 1'b1;
    chk("ign_ready", {31'd0, frame_ready}, 32'd0);
    tick(3);
    frame_valid = 1'b0;
    wait_done("ign_done");
    tick(5);
    chk("ign_busy", {31'd0, busy}, 32'd0);
    chk_seq("ign", 16'hBEEF, 1);

    // periodic refresh
    refresh_en = 1'b1;
    wait_start("ref1_start", 300, n);
    chk("ref1_cyc", n, 32'd101);
    wait_done("ref1_done");
    wait_start("ref2_start", 300, n);
    chk("ref2_cyc", n, 32'd101);
    wait_done("ref2_done");
    refresh_en = 1'b0;
    chk_seq("ref", 16'hBEEF, 2);
    tick(250);
    chk("ref_off", words.size(), 32'd0);

    // new frame coincident with refresh expiry
    refresh_en = 1'b1;
    tick(99);
    send(16'h7788);
    refresh_en = 1'b0;
    wait_done("col_done");
    chk_seq("col", 16'h7788, 1);

    // async reset in WAIT
    refresh_en = 1'b1;
    send(16'h5566);
    wait_start("ar_start", 20, n);
    tick(3);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_start0", {31'd0, start}, 32'd0);
    chk("ar_busy", {31'd0, busy}, 32'd0);
    chk("ar_par", {24'd0, par_in}, 32'd0);
    chk("ar_ready", {31'd0, frame_ready}, 32'd1);
    #2;
    rst_n = 1'b1;
    words.delete();
    tick(300);
    chk("ar_norefresh", words.size(), 32'd0);
    refresh_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
